// File: rtl/rv32_pkg.sv
// Shared widths and the writeback request payload for the RV32 core.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer moves to the loser after every grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       upd_en,
  output logic [1:0] gnt
);

  logic r_prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = r_prio ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prio <= 1'b0;
    end else if (upd_en && (gnt != 2'b00)) begin
      r_prio <= gnt[0];
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU/LSU writebacks into one register-file write port and
// tracks pending destination registers for issue-stage hazard checks.
module rf_wb_arbiter #(
  parameter int unsigned XLEN = rv32_pkg::XLEN,
  parameter int unsigned NREG = rv32_pkg::NREG,
  parameter int unsigned AW   = rv32_pkg::AW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  output logic            wb1_ready,
  input  logic            sb_set_en,
  input  logic [AW-1:0]   sb_set_rd,
  input  logic [AW-1:0]   rs1_q,
  input  logic [AW-1:0]   rs2_q,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_wn_en,
  output logic [AW-1:0]   rf_rd_addr,
  output logic [XLEN-1:0] rf_wr_data
);

  import rv32_pkg::*;

  logic [1:0]      w_req;
  logic [1:0]      w_gnt;
  wb_req_t         w_sel;
  logic            w_xfer;
  logic            w_wr;
  logic [NREG-1:0] w_pend_nxt;

  logic            r_wn_en;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_data;
  logic [NREG-1:0] r_pend;

  // Requests are masked while reset is asserted so no handshake can complete.
  assign w_req = {wb1_valid, wb0_valid} & {2{reset_n}};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (w_req),
    .upd_en  (reset_n),
    .gnt     (w_gnt)
  );

  assign wb0_ready = w_gnt[0];
  assign wb1_ready = w_gnt[1];
  assign w_xfer    = |w_gnt;
  assign w_sel     = w_gnt[1] ? wb_req_t'{rd: wb1_rd, data: wb1_data}
                              : wb_req_t'{rd: wb0_rd, data: wb0_data};
  assign w_wr      = w_xfer && (w_sel.rd != '0);

  // Clear on writeback first, then set, so a same-address set wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (r_wn_en) w_pend_nxt[r_addr] = 1'b0;
    if (sb_set_en && (sb_set_rd != '0)) w_pend_nxt[sb_set_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wn_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_pend  <= '0;
    end else begin
      r_wn_en <= w_wr;
      r_pend  <= w_pend_nxt;
      if (w_wr) begin
        r_addr <= w_sel.rd;
        r_data <= w_sel.data;
      end
    end
  end

  assign rf_wn_en   = r_wn_en;
  assign rf_rd_addr = r_addr;
  assign rf_wr_data = r_data;
  assign rs1_busy   = reset_n && r_pend[rs1_q];
  assign rs2_busy   = reset_n && r_pend[rs2_q];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed checks of rf_wb_arbiter against a cycle-level reference model.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [4:0]  wb0_rd, wb1_rd, sb_set_rd, rs1_q, rs2_q, rf_rd_addr;
  logic [31:0] wb0_data, wb1_data, rf_wr_data;
  logic        sb_set_en, rs1_busy, rs2_busy, rf_wn_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_prio;
  bit          m_pend [32];
  bit          m_wn;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_g0, m_g1;
  int          grant_log [$];

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .sb_set_en(sb_set_en), .sb_set_rd(sb_set_rd),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_wn_en(rf_wn_en), .rf_rd_addr(rf_rd_addr), .rf_wr_data(rf_wr_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prio = 0;
    m_wn   = 0;
    m_addr = '0;
    m_data = '0;
    foreach (m_pend[i]) m_pend[i] = 0;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit b1, b2;
    @(negedge clk);
    m_g0 = 0;
    m_g1 = 0;
    if (reset_n) begin
      if (wb0_valid && wb1_valid) begin
        m_g0 = (m_prio == 0);
        m_g1 = (m_prio == 1);
      end else begin
        m_g0 = wb0_valid;
        m_g1 = wb1_valid;
      end
    end
    b1 = reset_n && (rs1_q != 0) && m_pend[rs1_q];
    b2 = reset_n && (rs2_q != 0) && m_pend[rs2_q];
    check("wb0_ready",  64'(wb0_ready),  64'(m_g0));
    check("wb1_ready",  64'(wb1_ready),  64'(m_g1));
    check("rf_wn_en",   64'(rf_wn_en),   64'(m_wn));
    check("rf_rd_addr", 64'(rf_rd_addr), 64'(m_addr));
    check("rf_wr_data", 64'(rf_wr_data), 64'(m_data));
    check("rs1_busy",   64'(rs1_busy),   64'(b1));
    check("rs2_busy",   64'(rs2_busy),   64'(b2));
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (m_wn) m_pend[m_addr] = 0;
      if (sb_set_en && sb_set_rd != 0) m_pend[sb_set_rd] = 1;
      m_wn = 0;
      if (m_g0 || m_g1) begin
        logic [4:0]  rd = m_g0 ? wb0_rd : wb1_rd;
        logic [31:0] d  = m_g0 ? wb0_data : wb1_data;
        grant_log.push_back(m_g0 ? 0 : 1);
        m_prio = m_g0 ? 1 : 0;
        if (rd != 0) begin
          m_wn   = 1;
          m_addr = rd;
          m_data = d;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb0_valid = 0; wb1_valid = 0; sb_set_en = 0;
    wb0_rd = '0; wb1_rd = '0; wb0_data = '0; wb1_data = '0;
    sb_set_rd = '0; rs1_q = '0; rs2_q = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    cycle();
    reset_n = 1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset_n = 0;
    @(posedge clk);
    #1;

    // Reset then idle, busy query on an unset register
    rs1_q = 5'd5;
    cycle();
    reset_n = 1;
    cycle();

    // Single ALU writeback
    wb0_valid = 1; wb0_rd = 5'd3; wb0_data = 32'hDEADBEEF;
    cycle();
    wb0_valid = 0;
    cycle();
    cycle();

    // Continuous contention from reset: order 0,1,0,1
    do_reset();
    grant_log.delete();
    wb0_valid = 1; wb1_valid = 1;
    wb0_rd = 5'd1; wb1_rd = 5'd9;
    wb0_data = 32'hA000_0001; wb1_data = 32'hB000_0009;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (m_g0) begin wb0_rd = wb0_rd + 5'd1; wb0_data = wb0_data + 32'd1; end
      if (m_g1) begin wb1_rd = wb1_rd + 5'd1; wb1_data = wb1_data + 32'd1; end
    end
    wb0_valid = 0; wb1_valid = 0;
    cycle();
    cycle();
    check("grant_order", 64'(grant_log.size() == 4 && grant_log[0] == 0 && grant_log[1] == 1 &&
                             grant_log[2] == 0 && grant_log[3] == 1), 64'd1);

    // Scoreboard set/clear on rd=7, then set-wins on the clearing edge
    for (int rep = 0; rep < 2; rep++) begin
      sb_set_en = 1; sb_set_rd = 5'd7; rs2_q = 5'd7;
      cycle();
      sb_set_en = 0;
      cycle();
      wb1_valid = 1; wb1_rd = 5'd7; wb1_data = 32'h0000_7777;
      cycle();
      wb1_valid = 0;
      sb_set_en = (rep == 1);
      cycle();
      sb_set_en = 0;
      cycle();
      check("busy_after_clear", 64'(rs2_busy), 64'(rep == 1));
      cycle();
    end

    // x0 writeback with x0 scoreboard set
    wb0_valid = 1; wb0_rd = 5'd0; wb0_data = 32'h1234;
    sb_set_en = 1; sb_set_rd = 5'd0; rs1_q = 5'd0;
    cycle();
    wb0_valid = 0; sb_set_en = 0;
    cycle();
    cycle();

    // Reset on the edge after an accepted transfer
    sb_set_en = 1; sb_set_rd = 5'd12; rs1_q = 5'd12;
    wb0_valid = 1; wb0_rd = 5'd5; wb0_data = 32'h5555_AAAA;
    cycle();
    sb_set_en = 0; wb0_valid = 0;
    reset_n = 0;
    cycle();
    reset_n = 1;
    cycle();
    wb0_valid = 1; wb1_valid = 1; wb0_rd = 5'd2; wb1_rd = 5'd4;
    cycle();
    check("prio_after_reset", 64'(m_g0), 64'd1);
    wb0_valid = 0;
    cycle();
    wb1_valid = 0;
    cycle();

    // Randomized traffic honouring the hold-until-accepted rule
    for (int i = 0; i < 600; i++) begin
      if (!wb0_valid || m_g0) begin
        wb0_valid = ($urandom_range(0, 2) != 0);
        wb0_rd    = 5'($urandom_range(0, 31));
        wb0_data  = $urandom;
      end
      if (!wb1_valid || m_g1) begin
        wb1_valid = ($urandom_range(0, 2) != 0);
        wb1_rd    = 5'($urandom_range(0, 31));
        wb1_data  = $urandom;
      end
      sb_set_en = ($urandom_range(0, 1) != 0);
      sb_set_rd = 5'($urandom_range(0, 31));
      rs1_q     = 5'($urandom_range(0, 31));
      rs2_q     = 5'($urandom_range(0, 31));
      reset_n   = ($urandom_range(0, 79) != 0);
      cycle();
      if (!reset_n) begin m_g0 = 1; m_g1 = 1; end
    end
    reset_n = 1;
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
